// File: rtl/pseq_pkg.sv
// ============================================================================
// pseq_pkg
// Shared definitions for the power sequencer: state encoding, timer width
// and the index-width helper used for rail indices.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package pseq_pkg;

  // Width of the shared delay / timeout counter.
  localparam int TIMER_W = 16;

  // Sequencer state encoding; encodings 6 and 7 are illegal and recover to FAULT.
  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_UP_WAIT    = 3'd1,
    ST_UP_DELAY   = 3'd2,
    ST_ON         = 3'd3,
    ST_DOWN_DELAY = 3'd4,
    ST_FAULT      = 3'd5
  } pseq_state_t;

  // Bits needed to index n rails, never less than one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pseq_timer.sv
// ============================================================================
// pseq_timer
// Clearable, saturating up-counter with a terminal-compare flag. Shared by
// the step delay and the power-good timeout.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module pseq_timer
  import pseq_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_clear,
  input  logic [TIMER_W-1:0] i_terminal,
  output logic               o_done
);

  logic [TIMER_W-1:0] r_count;

  // Count up each cycle unless cleared; stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (r_count != {TIMER_W{1'b1}}) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_done = (r_count == i_terminal);

endmodule

`default_nettype wire

// File: rtl/power_sequencer.sv
// ============================================================================
// power_sequencer
// Brings NUM_RAILS regulator rails up in order (waiting for each power-good,
// then a fixed step delay) and down in reverse order. Missing power-good
// during ramp-up latches FAULT until cleared with power_on low.
// Optional macro POWER_SEQUENCER_MONITOR_EN: watch power-good while ON and
// fault on a loss lasting PG_FILTER consecutive cycles.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module power_sequencer
  import pseq_pkg::*;
#(
  parameter int NUM_RAILS  = 4,
  parameter int STEP_DELAY = 1000,
  parameter int PG_TIMEOUT = 10000,
  parameter int PG_FILTER  = 4
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                power_on,
  input  logic                                clear_fault,
  input  logic [NUM_RAILS-1:0]                rail_pg,
  output logic [NUM_RAILS-1:0]                rail_en,
  output logic                                pwr_good,
  output logic                                fault,
  output logic [idx_width(NUM_RAILS)-1:0]     fault_rail,
  output logic [2:0]                          seq_state
);

  localparam int IDX_W = idx_width(NUM_RAILS);
  localparam logic [IDX_W-1:0]   LAST_IDX     = IDX_W'(NUM_RAILS - 1);
  localparam logic [TIMER_W-1:0] DELAY_LAST   = TIMER_W'(STEP_DELAY - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(PG_TIMEOUT - 1);

  pseq_state_t          r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [NUM_RAILS-1:0] r_rail_en;
  logic                 r_pwr_good;
  logic                 r_fault;
  logic [IDX_W-1:0]     r_fault_rail;

  logic                 w_timer_done;
  logic                 w_timer_clr;
  logic [TIMER_W-1:0]   w_terminal;
  logic                 w_pg_idx;
  logic [IDX_W-1:0]     w_idx_next;
  logic [IDX_W-1:0]     w_idx_prev;
  logic [NUM_RAILS-1:0] w_low_hit;
  logic                 w_mon_hit;
  logic [IDX_W-1:0]     w_mon_idx;

  assign w_pg_idx   = rail_pg[r_idx];
  assign w_idx_next = r_idx + 1'b1;
  assign w_idx_prev = r_idx - 1'b1;
  assign w_terminal = (r_state == ST_UP_WAIT) ? TIMEOUT_LAST : DELAY_LAST;

  // Restart the timer on every edge that leaves or re-enters a timed phase,
  // and hold it at zero in the untimed states.
  always_comb begin
    w_timer_clr = 1'b1;
    case (r_state)
      ST_UP_WAIT:    w_timer_clr = w_pg_idx | w_timer_done | ~power_on;
      ST_UP_DELAY:   w_timer_clr = w_timer_done | ~power_on;
      ST_DOWN_DELAY: w_timer_clr = w_timer_done;
      default:       w_timer_clr = 1'b1;
    endcase
  end

  pseq_timer u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_clear    (w_timer_clr),
    .i_terminal (w_terminal),
    .o_done     (w_timer_done)
  );

`ifdef POWER_SEQUENCER_MONITOR_EN
  localparam logic [TIMER_W-1:0] FILTER_LAST = TIMER_W'(PG_FILTER - 1);

  for (genvar gi = 0; gi < NUM_RAILS; gi++) begin : g_pg_filter
    logic [TIMER_W-1:0] r_low_cnt;

    // Run length of consecutive low power-good samples while ON.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_low_cnt <= '0;
      end else if ((r_state == ST_ON) && !rail_pg[gi]) begin
        if (r_low_cnt != {TIMER_W{1'b1}}) begin
          r_low_cnt <= r_low_cnt + 1'b1;
        end
      end else begin
        r_low_cnt <= '0;
      end
    end

    assign w_low_hit[gi] = !rail_pg[gi] && (r_low_cnt >= FILTER_LAST);
  end
`else
  logic [31:0] w_unused_filter;
  assign w_unused_filter = PG_FILTER;
  assign w_low_hit       = '0;
`endif

  // Lowest-numbered rail whose power-good loss has outlasted the filter.
  always_comb begin
    w_mon_idx = '0;
    for (int i = NUM_RAILS - 1; i >= 0; i--) begin
      if (w_low_hit[i]) w_mon_idx = IDX_W'(i);
    end
    w_mon_hit = (r_state == ST_ON) && (|w_low_hit);
  end

  // Sequencer FSM: state, rail index, enables and registered status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_OFF;
      r_idx        <= '0;
      r_rail_en    <= '0;
      r_pwr_good   <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_rail <= '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          r_rail_en <= '0;
          if (power_on) begin
            r_state   <= ST_UP_WAIT;
            r_idx     <= '0;
            r_rail_en <= NUM_RAILS'(1);
          end
        end
        ST_UP_WAIT: begin
          if (w_timer_done && !w_pg_idx) begin
            r_state      <= ST_FAULT;
            r_rail_en    <= '0;
            r_fault      <= 1'b1;
            r_fault_rail <= r_idx;
          end else if (!power_on) begin
            r_state          <= ST_DOWN_DELAY;
            r_rail_en[r_idx] <= 1'b0;
          end else if (w_pg_idx) begin
            r_state <= ST_UP_DELAY;
          end
        end
        ST_UP_DELAY: begin
          if (!power_on) begin
            r_state          <= ST_DOWN_DELAY;
            r_rail_en[r_idx] <= 1'b0;
          end else if (w_timer_done) begin
            if (r_idx == LAST_IDX) begin
              r_state    <= ST_ON;
              r_pwr_good <= 1'b1;
            end else begin
              r_state               <= ST_UP_WAIT;
              r_idx                 <= w_idx_next;
              r_rail_en[w_idx_next] <= 1'b1;
            end
          end
        end
        ST_ON: begin
          if (w_mon_hit) begin
            r_state      <= ST_FAULT;
            r_rail_en    <= '0;
            r_pwr_good   <= 1'b0;
            r_fault      <= 1'b1;
            r_fault_rail <= w_mon_idx;
          end else if (!power_on) begin
            r_state             <= ST_DOWN_DELAY;
            r_idx               <= LAST_IDX;
            r_rail_en[LAST_IDX] <= 1'b0;
            r_pwr_good          <= 1'b0;
          end
        end
        ST_DOWN_DELAY: begin
          if (w_timer_done) begin
            if (r_idx == '0) begin
              r_state <= ST_OFF;
            end else begin
              r_idx                 <= w_idx_prev;
              r_rail_en[w_idx_prev] <= 1'b0;
            end
          end
        end
        ST_FAULT: begin
          if (clear_fault && !power_on) begin
            r_state <= ST_OFF;
            r_fault <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_FAULT;
          r_rail_en  <= '0;
          r_pwr_good <= 1'b0;
          r_fault    <= 1'b1;
        end
      endcase
    end
  end

  assign rail_en    = r_rail_en;
  assign pwr_good   = r_pwr_good;
  assign fault      = r_fault;
  assign fault_rail = r_fault_rail;
  assign seq_state  = r_state;

endmodule

`default_nettype wire
